// File: rtl/rd_capture_fifo.sv
// rd_capture_fifo: captures CAS-latency-aligned SDRAM read beats into a
// small FIFO, tagging the final beat of each burst with a last flag.
// Optional macro RD_CAPTURE_INREG_EN adds a register stage on rd_strobe/dq_in
// (strobe-to-valid latency becomes two cycles instead of one).
module rd_capture_fifo #(
    parameter int DW    = 16,
    parameter int BL    = 4,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_strobe,
    input  logic [DW-1:0] dq_in,
    input  logic          clear,
    output logic [DW-1:0] data_o,
    output logic          last_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          busy_o,
    output logic          ovf_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (BL > 1) ? $clog2(BL) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BL - 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    logic          stb;
    logic [DW-1:0] dq;

`ifdef RD_CAPTURE_INREG_EN
    logic          stb_q;
    logic [DW-1:0] dq_q;

    // Input register stage; a flush drops any beat still in flight.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            stb_q <= 1'b0;
            dq_q  <= '0;
        end else begin
            stb_q <= rd_strobe;
            dq_q  <= dq_in;
        end
    end

    assign stb = stb_q;
    assign dq  = dq_q;
`else
    assign stb = rd_strobe;
    assign dq  = dq_in;
`endif

    logic                state;
    logic [CW-1:0]       beat_cnt;
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic [DW:0]         mem [DEPTH];
    logic [DW:0]         head;
    logic                empty;
    logic                full;
    logic                pop;
    logic                push;
    logic                is_last;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push    = stb && (!full || pop);
    assign is_last = (beat_cnt == LAST_CNT);

    // Burst framing: count beats (including dropped ones) modulo BL.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
        end else if (stb) begin
            if (is_last) begin
                state    <= ST_IDLE;
                beat_cnt <= '0;
            end else begin
                state    <= ST_BURST;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // FIFO storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst && !clear && push) begin
            mem[wr_ptr[AW-1:0]] <= {is_last, dq};
        end
    end

    // Read/write pointer update with wrap bit.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky overflow: set when a beat arrives at a full FIFO with no pop.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ovf_o <= 1'b0;
        end else if (stb && full && !pop) begin
            ovf_o <= 1'b1;
        end
    end

    assign head    = mem[rd_ptr[AW-1:0]];
    assign valid_o = !empty;
    assign data_o  = empty ? '0 : head[DW-1:0];
    assign last_o  = !empty && head[DW];
    assign busy_o  = (state == ST_BURST);

endmodule

// File: doc/rd_capture_fifo.md
RD_CAPTURE_FIFO -- requirements
Module: rd_capture_fifo

Interface
REQ-001 Parameter DW, default 16: SDRAM data width in bits.
REQ-002 Parameter BL, default 4: burst length in beats; range 1..8.
REQ-003 Parameter DEPTH, default 8: FIFO entries; power of 2, at least BL.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port rd_strobe, input, 1: CAS-latency-aligned read-valid strobe from the delay stage; one beat per cycle when high.
REQ-007 Port dq_in, input, DW: SDRAM read data; sampled when rd_strobe=1.
REQ-008 Port clear, input, 1: synchronous flush of burst state and FIFO.
REQ-009 Port data_o, output, DW: head-of-FIFO data.
REQ-010 Port last_o, output, 1: head entry is the final beat of its burst.
REQ-011 Port valid_o, output, 1: head entry is valid.
REQ-012 Port ready_i, input, 1: consumer accepts the head when valid_o and ready_i are both 1.
REQ-013 Port busy_o, output, 1: a burst is in progress (beat count is not 0).
REQ-014 Port ovf_o, output, 1: sticky overflow flag.

Function
REQ-015 Burst state machine shall have two states: IDLE (beat_cnt=0) and BURST (beat_cnt 1..BL-1).
REQ-016 Transitions: an rd_strobe beat in IDLE sets beat_cnt=1 and moves to BURST (goes directly back to IDLE if BL=1); each beat in BURST increments beat_cnt; the beat at beat_cnt=BL-1 returns the block to IDLE with beat_cnt=0.
REQ-017 Strobes need not be contiguous: gaps hold beat_cnt with no timeout.
REQ-018 Each captured beat shall be written as the entry {last, dq_in}, with last=1 only when beat_cnt=BL-1 (always 1 when BL=1).
REQ-019 Write latency: a beat with rd_strobe high at edge N shall be visible with valid_o=1 from cycle N+1.
REQ-020 Pop occurs when valid_o=1 and ready_i=1; the head advances at that edge.
REQ-021 data_o and last_o shall be 0 when the FIFO is empty.
REQ-022 Full and no pop in the same cycle: an incoming beat is dropped, ovf_o is set, and beat_cnt still advances so burst framing is kept.
REQ-023 Full with a pop in the same cycle: the beat is accepted and occupancy is unchanged.
REQ-024 Empty with a strobe in the same cycle: no bypass; valid_o rises the next cycle.
REQ-025 Pointers are log2(DEPTH) bits with one extra wrap bit; full and empty are decoded from pointer equality and the wrap bit.
REQ-026 Occupancy shall never exceed DEPTH and never underflow; a pop while empty is ignored.
REQ-027 clear: at the edge, pointers, beat_cnt and ovf_o reset; any strobe or pop in the same cycle is ignored.
REQ-028 ovf_o shall clear only on rst or clear.

Reset
REQ-029 While rst=1 at a rising edge: valid_o=0, last_o=0, data_o=0, busy_o=0, ovf_o=0, pointers=0, beat_cnt=0.
REQ-030 Reset shall take priority over clear, rd_strobe and ready_i.
REQ-031 Reset mid-burst discards partial bursts and all stored entries; the first strobe after reset starts a new burst.
REQ-032 FIFO storage contents need no reset.

Configuration
REQ-033 Macro RD_CAPTURE_INREG_EN, when defined, adds one register stage on rd_strobe and dq_in, cleared by rst and by clear.
REQ-034 With RD_CAPTURE_INREG_EN defined, latency from strobe at edge N to valid_o is N+2.
REQ-035 Without RD_CAPTURE_INREG_EN, there is no input register and latency is N+1.
REQ-036 All other behaviour shall be identical with and without the macro.

Verification
REQ-037 BL=4, ready_i=1, strobes on 4 consecutive cycles with dq=0x1111..0x4444 -> valid_o on 4 cycles starting one cycle after the first strobe, data 0x1111..0x4444, last_o only on 0x4444.
REQ-038 ready_i=0, strobe with 2-cycle gaps for 4 beats -> busy_o high from beat 1 until beat 4, then 4 entries queued, last_o on entry 4, ovf_o=0.
REQ-039 ready_i=0, 9 beats at DEPTH=8 -> 9th beat dropped, ovf_o=1, 8 entries intact; 3rd burst beat_cnt alignment correct (next burst's last on beat 12).
REQ-040 FIFO full with simultaneous strobe and pop -> occupancy stays 8, ovf_o=0, order preserved.
REQ-041 clear asserted after beat 2 of a burst -> valid_o=0 next cycle, busy_o=0, ovf_o=0; next 4 strobes form a complete burst with last_o on beat 4.
REQ-042 rst asserted mid-burst with 3 entries queued -> all outputs 0 next cycle; with RD_CAPTURE_INREG_EN defined, the single-burst test shows valid_o one cycle later than without it.
